// File: rtl/sfu_lut_loader_pkg.sv
// Shared types and default geometry for the SFU LUT loader.
// Optional checksum logic in the top is enabled by SFU_LUT_LOADER_CHECKSUM_EN.
package sfu_lut_loader_pkg;

    localparam int unsigned LutDepthDefault = 4096;
    localparam int unsigned AddrWDefault    = 12;
    localparam int unsigned DataWDefault    = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSettle,
        StKick
    } lut_state_e;

endpackage

// File: rtl/sfu_lut_loader.sv
// Streams LUT_DEPTH words into the SFU LUT, waits SETTLE_CYCLES, then kicks the config register.
// Define SFU_LUT_LOADER_CHECKSUM_EN to add a running checksum compared against expected_sum.
module sfu_lut_loader
    import sfu_lut_loader_pkg::*;
#(
    parameter int unsigned LUT_DEPTH     = LutDepthDefault,
    parameter int unsigned ADDR_W        = AddrWDefault,
    parameter int unsigned DATA_W        = DataWDefault,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              write_lut,
    output logic [ADDR_W-1:0] write_lut_addr,
    output logic [DATA_W-1:0] write_lut_data,
    output logic              dma_cfg_en,
    output logic              cfg_wr_en,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] expected_sum,
    output logic              sum_err
);

    localparam int unsigned       SetW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(LUT_DEPTH - 1);
    localparam logic [SetW-1:0]   SettleLoad = SetW'(SETTLE_CYCLES - 1);

    lut_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic              beat;

    logic              wr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              kick_q;

    assign beat = (state_q == StLoad) && in_valid;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (beat) begin
                    // Counter parks on the last address instead of wrapping.
                    if (cnt_q == LastAddr) begin
                        state_d  = StSettle;
                        settle_d = SettleLoad;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            StSettle: begin
                if (settle_q == '0) begin
                    state_d = StKick;
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            StKick: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
        end
    end

    // Write port is registered; address/data hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            kick_q    <= 1'b0;
        end else begin
            wr_q   <= beat;
            kick_q <= (state_q == StKick);
            if (beat) begin
                wr_addr_q <= cnt_q;
                wr_data_q <= in_data;
            end
        end
    end

    assign in_ready       = (state_q == StLoad);
    assign dma_cfg_en     = (state_q == StLoad) || (state_q == StSettle);
    assign busy           = (state_q != StIdle);
    assign write_lut      = wr_q;
    assign write_lut_addr = wr_addr_q;
    assign write_lut_data = wr_data_q;
    assign cfg_wr_en      = kick_q;
    assign done           = kick_q;

`ifdef SFU_LUT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic              sum_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            sum_err_q <= 1'b0;
        end else begin
            if ((state_q == StIdle) && start) begin
                sum_q     <= '0;
                sum_err_q <= 1'b0;
            end else if (beat) begin
                sum_q <= sum_q + in_data;
            end
            if (state_q == StKick) begin
                sum_err_q <= (sum_q != expected_sum);
            end
        end
    end

    assign sum_err = sum_err_q;
`else
    logic unused_expected_sum;
    assign unused_expected_sum = ^expected_sum;
    assign sum_err             = 1'b0;
`endif

endmodule

// File: tb/tb_sfu_lut_loader.sv
// Scoreboard bench for sfu_lut_loader; checksum cases run when SFU_LUT_LOADER_CHECKSUM_EN is set.
module tb_sfu_lut_loader;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int MIdle = 0, MLoad = 1, MSettle = 2, MKick = 3;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          write_lut;
    logic [AW-1:0] write_lut_addr;
    logic [DW-1:0] write_lut_data;
    logic          dma_cfg_en;
    logic          cfg_wr_en;
    logic          busy;
    logic          done;
    logic [DW-1:0] expected_sum;
    logic          sum_err;

    logic [34:0]   outs;
    assign outs = {in_ready, write_lut, write_lut_addr, write_lut_data,
                   dma_cfg_en, cfg_wr_en, busy, done, sum_err};

    sfu_lut_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .write_lut     (write_lut),
        .write_lut_addr(write_lut_addr),
        .write_lut_data(write_lut_data),
        .dma_cfg_en    (dma_cfg_en),
        .cfg_wr_en     (cfg_wr_en),
        .busy          (busy),
        .done          (done),
        .expected_sum  (expected_sum),
        .sum_err       (sum_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks loader state for the current cycle, judged at negedge.
    beat_t    exp_q[$];
    beat_t    e;
    int       m_state = MIdle;
    int       m_addr  = 0;
    int       m_settle = 0;
    int       kick_cnt = 0;
    logic     exp_wr, exp_kick, set_kick;
    logic     done_flag = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            m_state  = MIdle;
            m_addr   = 0;
            kick_cnt = 0;
            exp_q.delete();
        end else begin
            check("ctl", {in_ready, dma_cfg_en, busy},
                  {m_state == MLoad, m_state == MLoad || m_state == MSettle, m_state != MIdle});
            exp_wr   = (exp_q.size() != 0);
            set_kick = 1'b0;
            check("write_lut", write_lut, exp_wr);
            if (write_lut && exp_wr) begin
                e = exp_q.pop_front();
                check("wr_addr", write_lut_addr, e.a);
                check("wr_data", write_lut_data, e.d);
                if (e.a == AW'(DEPTH - 1)) set_kick = 1'b1;
            end
            exp_kick = 1'b0;
            if (kick_cnt > 0) begin
                kick_cnt--;
                exp_kick = (kick_cnt == 0);
            end
            if (set_kick) kick_cnt = 9;
            if (exp_kick || cfg_wr_en || done)
                check("kick", {cfg_wr_en, done}, exp_kick ? 2'b11 : 2'b00);
            if (exp_kick) done_flag = 1'b1;

            case (m_state)
                MIdle: if (start) begin
                    m_state = MLoad;
                    m_addr  = 0;
                end
                MLoad: if (in_valid) begin
                    exp_q.push_back('{a: AW'(m_addr), d: in_data});
                    if (m_addr == DEPTH - 1) begin
                        m_state  = MSettle;
                        m_settle = 8;
                    end else begin
                        m_addr++;
                    end
                end
                MSettle: begin
                    m_settle--;
                    if (m_settle == 0) m_state = MKick;
                end
                default: m_state = MIdle;
            endcase
        end
    end

    // gap: percent of cycles with in_valid low; restart_beat/rst_beat < 0 disables them.
    task automatic do_load(input int gap, input int restart_beat, input int rst_beat);
        int  beat = 0;
        int  cycles = 0;
        bit  pulsed = 0;
        done_flag = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (beat < DEPTH && cycles < 60000) begin
            if (beat == rst_beat) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                start    = 1'b0;
                #1 check("rst_outs_mid", outs, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                repeat (20) @(posedge clk);
                check("no_done_after_rst", done_flag, 0);
                return;
            end
            in_valid = ($urandom_range(99) >= gap);
            in_data  = DW'(beat);
            start    = 1'b0;
            if (beat == restart_beat && !pulsed) begin
                start  = 1'b1;
                pulsed = 1;
            end
            @(posedge clk); #1;
            if (in_valid) beat++;
            cycles++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("load_complete", beat, DEPTH);
        repeat (30) begin
            @(posedge clk);
            if (done_flag) break;
        end
        check("done_seen", done_flag, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        expected_sum = 16'hF800;
        #1 check("rst_outs", outs, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_load(0, -1, -1);
        check("sum_err_ok", sum_err, 0);
        do_load(50, -1, -1);
        do_load(20, 100, -1);
        do_load(20, -1, 2000);
        do_load(0, -1, -1);
        check("idle_after_load", {busy, in_ready, dma_cfg_en}, 0);
`ifdef SFU_LUT_LOADER_CHECKSUM_EN
        check("sum_err_match", sum_err, 0);
        expected_sum = 16'h0000;
        do_load(0, -1, -1);
        check("sum_err_mismatch", sum_err, 1);
`else
        check("sum_err_tied", sum_err, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
